// File: rtl/keypad_hit_scanner.sv
// 4x4 active-low keypad scanner: synchronises rows, debounces one key at a time
// and emits a single-cycle hit with hit_index = row*4 + col per accepted press.
module keypad_hit_scanner #(
  parameter int SCAN_DIV     = 16,
  parameter int DEBOUNCE_CNT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic       hit,
  output logic [3:0] hit_index,
  output logic       key_held
);
  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  localparam logic [15:0] TICK_AT = 16'(SCAN_DIV - 1);
  localparam logic [7:0]  DB_N    = 8'(DEBOUNCE_CNT);

  state_t      state;
  logic [3:0]  sync1, row_s;
  logic [15:0] scan_cnt;
  logic [1:0]  col, cand_row, dec_row;
  logic [3:0]  cand_index;
  logic [7:0]  stable_cnt, rel_cnt;
  logic        tick, any_low;

  assign tick    = scan_cnt == TICK_AT;
  assign any_low = row_s != 4'hF;
  assign col_out = ~(4'b0001 << col);

  // lowest-index low row wins when several rows read low
  always_comb begin
    dec_row = 2'd3;
    if (!row_s[2]) dec_row = 2'd2;
    if (!row_s[1]) dec_row = 2'd1;
    if (!row_s[0]) dec_row = 2'd0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1    <= 4'hF;
      row_s    <= 4'hF;
      scan_cnt <= '0;
    end else begin
      sync1    <= row_in;
      row_s    <= sync1;
      scan_cnt <= tick ? 16'd0 : scan_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= SCAN;
      col        <= 2'd0;
      cand_row   <= 2'd0;
      cand_index <= 4'd0;
      stable_cnt <= 8'd0;
      rel_cnt    <= 8'd0;
      hit        <= 1'b0;
      hit_index  <= 4'd0;
      key_held   <= 1'b0;
    end else begin
      hit <= 1'b0;
      if (tick) begin
        case (state)
          SCAN: begin
            if (any_low) begin
              cand_row   <= dec_row;
              cand_index <= {dec_row, col};
              if (DB_N == 8'd1) begin
                hit        <= 1'b1;
                hit_index  <= {dec_row, col};
                key_held   <= 1'b1;
                rel_cnt    <= 8'd0;
                stable_cnt <= 8'd0;
                state      <= HELD;
              end else begin
                stable_cnt <= 8'd1;
                state      <= DEBOUNCE;
              end
            end else begin
              col <= col + 2'd1;
            end
          end
          DEBOUNCE: begin
            if (any_low && dec_row == cand_row) begin
              if (stable_cnt + 8'd1 == DB_N) begin
                hit        <= 1'b1;
                hit_index  <= cand_index;
                key_held   <= 1'b1;
                rel_cnt    <= 8'd0;
                stable_cnt <= 8'd0;
                state      <= HELD;
              end else begin
                stable_cnt <= stable_cnt + 8'd1;
              end
            end else begin
              stable_cnt <= 8'd0;
              col        <= col + 2'd1;
              state      <= SCAN;
            end
          end
          HELD: begin
            // only the accepted key's row matters; other presses are ignored
            if (row_s[cand_row]) begin
              if (rel_cnt + 8'd1 == DB_N) begin
                rel_cnt  <= 8'd0;
                key_held <= 1'b0;
                col      <= col + 2'd1;
                state    <= SCAN;
              end else begin
                rel_cnt <= rel_cnt + 8'd1;
              end
            end else begin
              rel_cnt <= 8'd0;
            end
          end
          default: state <= SCAN;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_keypad_hit_scanner.sv
// Bench for keypad_hit_scanner: physical keypad model, per-cycle reference model,
// vector table for the main scenarios and hand sequences for bounce and reset.
module tb_keypad_hit_scanner;
  localparam int SD = 4;
  localparam int DB = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  row_in, col_out, hit_index;
  logic        hit, key_held;
  logic [15:0] pressed = '0;

  int checks = 0, failures = 0, hit_cnt = 0;

  keypad_hit_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
    .clk(clk), .rst(rst), .row_in(row_in), .col_out(col_out),
    .hit(hit), .hit_index(hit_index), .key_held(key_held)
  );

  always #5 clk = ~clk;

  // a row reads low when any pressed key in it sits on the driven column
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  // reference model: samples seen every SD cycles through a 2-cycle delay line
  logic [3:0]  m_pipe[$];
  int          m_col, m_cand_row, m_cand_col, m_run, m_quiet, m_idx;
  bit          m_cand, m_hold, m_hit;
  int unsigned m_edge;
  logic [3:0]  exp_col;

  function automatic int lowest_low(input logic [3:0] v);
    for (int r = 0; r < 4; r++) if (!v[r]) return r;
    return -1;
  endfunction

  task automatic m_reset();
    m_pipe.delete();
    m_pipe.push_back(4'hF);
    m_pipe.push_back(4'hF);
    m_col = 0; m_cand = 0; m_cand_row = 0; m_cand_col = 0; m_run = 0;
    m_hold = 0; m_quiet = 0; m_hit = 0; m_idx = 0; m_edge = 0;
  endtask

  task automatic m_accept();
    m_hit  = 1;
    m_idx  = m_cand_row * 4 + m_cand_col;
    m_hold = 1;
    m_cand = 0;
    m_run  = 0;
    m_quiet = 0;
  endtask

  task automatic m_step(input logic [3:0] rin);
    logic [3:0] rs;
    int r;
    rs = m_pipe.pop_front();
    m_pipe.push_back(rin);
    m_hit = 0;
    if (m_edge % SD == SD - 1) begin
      r = lowest_low(rs);
      if (m_hold) begin
        if (rs[m_cand_row]) begin
          m_quiet++;
          if (m_quiet == DB) begin m_hold = 0; m_col = (m_col + 1) % 4; end
        end else m_quiet = 0;
      end else if (!m_cand) begin
        if (r >= 0) begin
          m_cand = 1; m_cand_row = r; m_cand_col = m_col; m_run = 1;
          if (m_run == DB) m_accept();
        end else m_col = (m_col + 1) % 4;
      end else if (r == m_cand_row) begin
        m_run++;
        if (m_run == DB) m_accept();
      end else begin
        m_cand = 0; m_run = 0; m_col = (m_col + 1) % 4;
      end
    end
    m_edge++;
  endtask

  initial forever begin
    @(negedge clk);
    if (!rst) m_reset();
    exp_col = ~(4'b0001 << m_col);
    checks++;
    if (col_out !== exp_col || hit !== m_hit || hit_index !== m_idx[3:0] || key_held !== m_hold) begin
      failures++;
      $display("FAIL model t=%0t got col=%b hit=%b idx=%0d held=%b want col=%b hit=%b idx=%0d held=%b",
               $time, col_out, hit, hit_index, key_held, exp_col, m_hit, m_idx, m_hold);
    end
    if (hit) hit_cnt++;
    if (rst) m_step(row_in);
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic wait_run2(input string name);
    int n;
    n = 0;
    while (!(m_cand && m_run == 2) && n < 200) begin step(1); n++; end
    chk(name, (n < 200) ? 1 : 0, 1);
  endtask

  typedef struct {
    int k0; int k1; int k1_dly; int hold; int gap; int exp_hits; int exp_idx;
  } vec_t;
  vec_t vecs[6];

  int h0, k;

  initial begin
    vecs[0] = '{9, -1, 0, 200, 40, 1, 9};
    vecs[1] = '{3, -1, 0, 60, 40, 1, 3};
    vecs[2] = '{3, -1, 0, 60, 40, 1, 3};
    vecs[3] = '{4, 12, 0, 80, 40, 1, 4};
    vecs[4] = '{15, 0, 60, 120, 40, 1, 15};
    vecs[5] = '{-1, -1, 0, 50, 20, 0, 15};

    step(3);
    chk("reset_col", col_out, 4'b1110);
    chk("reset_hit", hit, 0);
    chk("reset_idx", hit_index, 0);
    chk("reset_held", key_held, 0);
    rst = 1'b1;

    for (int i = 0; i < 6; i++) begin
      h0 = hit_cnt;
      pressed = '0;
      if (vecs[i].k0 >= 0) pressed[vecs[i].k0] = 1'b1;
      if (vecs[i].k1 >= 0) begin
        step(vecs[i].k1_dly);
        pressed[vecs[i].k1] = 1'b1;
        step(vecs[i].hold - vecs[i].k1_dly);
      end else step(vecs[i].hold);
      chk($sformatf("vec%0d_held", i), key_held, (vecs[i].exp_hits > 0) ? 1 : 0);
      pressed = '0;
      step(vecs[i].gap);
      chk($sformatf("vec%0d_hits", i), hit_cnt - h0, vecs[i].exp_hits);
      chk($sformatf("vec%0d_idx", i), hit_index, vecs[i].exp_idx);
      chk($sformatf("vec%0d_released", i), key_held, 0);
    end

    // bounce: two good samples then release aborts and moves on to column 2
    h0 = hit_cnt;
    pressed = '0; pressed[9] = 1'b1;
    wait_run2("bounce_wait");
    pressed = '0;
    step(4);
    chk("bounce_col", col_out, 4'b1011);
    chk("bounce_held", key_held, 0);
    step(20);
    chk("bounce_hits", hit_cnt - h0, 0);

    // reset in the middle of debounce, key kept down through it
    pressed = '0; pressed[6] = 1'b1;
    wait_run2("rst_wait");
    rst = 1'b0;
    #1;
    chk("rst_col", col_out, 4'b1110);
    chk("rst_hit", hit, 0);
    chk("rst_idx", hit_index, 0);
    chk("rst_held", key_held, 0);
    step(2);
    rst = 1'b1;
    h0 = hit_cnt;
    step(80);
    chk("rst_rehit", hit_cnt - h0, 1);
    chk("rst_reidx", hit_index, 6);
    chk("rst_reheld", key_held, 1);
    pressed = '0;
    step(40);
    chk("rst_release", key_held, 0);

    for (int it = 0; it < 25; it++) begin
      k = $urandom_range(0, 15);
      pressed = '0;
      pressed[k] = 1'b1;
      if ($urandom_range(0, 3) == 0) pressed[$urandom_range(0, 15)] = 1'b1;
      step($urandom_range(1, 60));
      if ($urandom_range(0, 1) == 1) begin
        pressed = '0;
        step($urandom_range(1, 12));
        pressed[k] = 1'b1;
        step($urandom_range(1, 40));
      end
      if ($urandom_range(0, 7) == 0) begin
        rst = 1'b0;
        step($urandom_range(1, 3));
        rst = 1'b1;
      end
      pressed = '0;
      step($urandom_range(1, 50));
    end
    step(60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
